cascade_ack_sequencer: RTL
==========================

Name: cascade_ack_sequencer

Overview:
Parametrised, clocked successor to the 8259A cascade logic. Tracks the INTA pulse sequence (ACK1..ACK3) and, as master, latches the acknowledged IR and drives the slave ID onto CAS. As slave, latches CAS during ACK1 and decides whether this device drives the vector. Sits between the control-logic FSM / priority resolver and the data-bus buffer. Generalised in IR count and CAS width, with an 8086/8080 pulse-count mode.

Parameters:
NUM_IR, 8, number of interrupt request lines (2..32)
CAS_W, 3, cascade bus width; must equal clog2(NUM_IR)
TIMEOUT_CYCLES, 64, idle-cycle limit used only with CASCADE_TIMEOUT_EN

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
single_mode  in  1  ICW1 SNGL; 1 = no cascade
is_master  in  1  resolved master(1)/slave(0) role
mode_8086  in  1  1 = two INTA pulses, 0 = three (8080)
slave_map  in  NUM_IR  master ICW3; bit i = slave on IR i
slave_id  in  CAS_W  slave ICW3 own ID
ack_ir  in  NUM_IR  one-hot IR being acknowledged (from priority resolver)
inta_n  in  1  synchronised INTA, active low
cas_in  in  CAS_W  CAS lines as received
cas_out  out  CAS_W  CAS value driven by master
cas_oe  out  1  CAS output enable
ack_state  out  2  0=IDLE, 1=ACK1, 2=ACK2, 3=ACK3
drive_vector_en  out  1  this device drives the data bus now
ack_done  out  1  one-cycle pulse at sequence end
ack_error  out  1  one-cycle pulse on empty ack_ir or timeout

Behaviour:
- Reset: state IDLE. cas_out=0, cas_oe=0, drive_vector_en=0, ack_done=0, ack_error=0. inta_prev=1 (no false edge). Reset mid-sequence aborts in one cycle with no ack_done.
- Edge detect: fall = inta_prev & ~inta_n; rise = ~inta_prev & inta_n. inta_prev is registered each cycle.
- FSM advances on fall: IDLE->ACK1->ACK2->ACK3.
- Final pulse: ACK2 in 8086 mode, ACK3 in 8080 mode. On its rise: state->IDLE, ack_done=1 for one cycle. mode_8086 is latched at IDLE->ACK1.
- fall while in ACK3 (8080 mode) or ACK2 (8086 mode) before rise: ignored, because INTA cannot re-fall without rising first.
- Entry to ACK1: latch ack_ir, slave_map and single_mode. Configuration changes later in the sequence have no effect.
- ack_ir==0 at ACK1 entry: ack_error pulses and the sequence is treated as a non-cascade master sequence.
- Master cascade hit: hit = ~single_mode & is_master & |(ack_ir_l & slave_map_l).
  - cas_out = binary index of the lowest set bit of ack_ir_l.
  - cas_oe=1 from the cycle after ACK1 entry until the cycle after return to IDLE.
  - Without a hit, cas_oe=0 and cas_out=0.
- Slave (is_master=0, single_mode=0): on the rise ending ACK1, latch match = (cas_in==slave_id). match clears on return to IDLE.
- drive_vector_en is registered and is 1 while state∈{ACK2,ACK3} and inta_n==0 and any of:
  - single_mode_l
  - master without a hit
  - slave with match
- drive_vector_en is never 1 in ACK1 or IDLE.
- Latency: every output is registered, one cycle after the triggering inta_n sample.

Optional Feature:
CASCADE_TIMEOUT_EN:
- Defined: a counter runs while state!=IDLE and inta_n==1, and clears on any fall. On reaching TIMEOUT_CYCLES: state->IDLE, ack_error pulses, cas_oe and drive_vector_en drop, no ack_done.
- Undefined: the FSM waits indefinitely and the counter is not synthesised.

Decomposition:
- Package cascade_pkg: ack_state_t enum (IDLE, ACK1, ACK2, ACK3), CAS_W helper function, lowest-set-bit encoder function.
- One sub-module, inta_edge_detect (registered fall/rise pulses), reused by the control-logic FSM.

Test Plan:
- Master, 8086 mode, slave_map=8'h04, ack_ir=8'h04, two INTA pulses -> cas_oe=1, cas_out=3'd2, drive_vector_en stays 0, ack_done after pulse 2, ack_state 1,2,0.
- Master, 8080 mode, slave_map=0, ack_ir=8'h80, three pulses -> cas_oe=0, drive_vector_en=1 during pulses 2 and 3, ack_done after pulse 3.
- Slave, slave_id=3'd5, cas_in=5 in ACK1 -> drive_vector_en=1 in ACK2. Repeat with cas_in=4 -> stays 0.
- ack_ir=0 at first fall -> ack_error one cycle, sequence completes, ack_done asserted.
- reset asserted during ACK2 with cas_oe=1 -> next cycle all outputs 0 and ack_state=0. A new INTA restarts at ACK1.
- CASCADE_TIMEOUT_EN, TIMEOUT_CYCLES=16, inta_n held high after pulse 1 -> ack_error at cycle 16, ack_state=0, no ack_done.

Source files
------------

// File: rtl/cascade_pkg.sv
// Shared types and helpers for the INTA cascade sequencer.
package cascade_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK1 = 2'd1,
    ACK2 = 2'd2,
    ACK3 = 2'd3
  } ack_state_t;

  function automatic int cas_width(input int num_ir);
    return $clog2(num_ir);
  endfunction

  // Scanning from the top down leaves the lowest set bit as the final answer.
  function automatic logic [4:0] lsb_index(input logic [31:0] vec);
    logic [4:0] idx;
    idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/inta_edge_detect.sv
// INTA edge pulses computed against the registered previous sample, so the
// consumer's registered outputs change one cycle after the triggering sample.
module inta_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic inta_n,
  output logic fall,
  output logic rise
);

  logic inta_prev;

  // Reset to the idle-high level so no false edge appears after reset.
  always_ff @(posedge clock) begin
    if (reset) inta_prev <= 1'b1;
    else       inta_prev <= inta_n;
  end

  assign fall = inta_prev & ~inta_n;
  assign rise = ~inta_prev & inta_n;

endmodule

// File: rtl/cascade_ack_sequencer.sv
// 8259A-style cascade/INTA sequencer. Optional abort on an idle INTA line
// is built when CASCADE_TIMEOUT_EN is defined.
module cascade_ack_sequencer
  import cascade_pkg::*;
#(
  parameter int NUM_IR         = 8,
  parameter int CAS_W          = cas_width(NUM_IR),
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              single_mode,
  input  logic              is_master,
  input  logic              mode_8086,
  input  logic [NUM_IR-1:0] slave_map,
  input  logic [CAS_W-1:0]  slave_id,
  input  logic [NUM_IR-1:0] ack_ir,
  input  logic              inta_n,
  input  logic [CAS_W-1:0]  cas_in,
  output logic [CAS_W-1:0]  cas_out,
  output logic              cas_oe,
  output logic [1:0]        ack_state,
  output logic              drive_vector_en,
  output logic              ack_done,
  output logic              ack_error
);

  ack_state_t state_q, state_d;
  logic fall, rise;

  logic [NUM_IR-1:0] ack_ir_l, slave_map_l;
  logic              single_mode_l, mode_8086_l, empty_l, match_q;
  logic [CAS_W-1:0]  cas_out_q, cas_out_d;
  logic              cas_oe_q, cas_oe_d, dve_q, dve_d;
  logic              done_q, done_d, err_q, err_d;
  logic              hit, drive_cond, entering, timeout_hit;

  inta_edge_detect u_edge (
    .clock  (clock),
    .reset  (reset),
    .inta_n (inta_n),
    .fall   (fall),
    .rise   (rise)
  );

`ifdef CASCADE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] idle_cnt_q;

  always_ff @(posedge clock) begin
    if (reset || state_q == IDLE || fall || timeout_hit) idle_cnt_q <= '0;
    else if (inta_n)                                      idle_cnt_q <= idle_cnt_q + 1'b1;
  end

  assign timeout_hit = (state_q != IDLE) && inta_n &&
                       (idle_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  // Never fires; the limit only matters when the timeout is built.
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

  assign hit = ~single_mode_l & is_master & (|(ack_ir_l & slave_map_l));
  // An empty acknowledge is handled as a plain non-cascade master cycle.
  assign drive_cond = single_mode_l | empty_l | (is_master & ~hit) |
                      (~is_master & match_q);
  assign entering = (state_q == IDLE) && (state_d == ACK1);

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: if (fall) begin
        state_d = ACK1;
        err_d   = (ack_ir == '0);
      end
      ACK1: if (fall) state_d = ACK2;
      ACK2: begin
        if (mode_8086_l) begin
          if (rise) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else if (fall) begin
          state_d = ACK3;
        end
      end
      ACK3: if (rise) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (timeout_hit && state_d != IDLE) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end

    cas_oe_d  = (state_q != IDLE) && hit;
    cas_out_d = cas_oe_d ? CAS_W'(lsb_index(32'(ack_ir_l))) : '0;
    dve_d     = ((state_d == ACK2) || (state_d == ACK3)) && !inta_n && drive_cond;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      ack_ir_l      <= '0;
      slave_map_l   <= '0;
      single_mode_l <= 1'b0;
      mode_8086_l   <= 1'b0;
      empty_l       <= 1'b0;
      match_q       <= 1'b0;
      cas_out_q     <= '0;
      cas_oe_q      <= 1'b0;
      dve_q         <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q   <= state_d;
      cas_out_q <= cas_out_d;
      cas_oe_q  <= cas_oe_d;
      dve_q     <= dve_d;
      done_q    <= done_d;
      err_q     <= err_d;
      if (entering) begin
        ack_ir_l      <= ack_ir;
        slave_map_l   <= slave_map;
        single_mode_l <= single_mode;
        mode_8086_l   <= mode_8086;
        empty_l       <= (ack_ir == '0);
      end
      if (state_d == IDLE)
        match_q <= 1'b0;
      else if (state_q == ACK1 && rise && !is_master && !single_mode_l)
        match_q <= (cas_in == slave_id);
    end
  end

  assign ack_state       = state_q;
  assign cas_out         = cas_out_q;
  assign cas_oe          = cas_oe_q;
  assign drive_vector_en = dve_q;
  assign ack_done        = done_q;
  assign ack_error       = err_q;

endmodule
